alu_issue_wb: RTL
=================

# alu_issue_wb

Issue and writeback sequencer for the datapath ALU. It accepts one operation at a time over a valid/ready request port and drives the ALU's operand and opcode inputs. It waits an opcode-dependent number of cycles, captures the 64-bit ALU result into an internal Z register, and returns it to the register file over a valid/ready writeback port. Mul and div results go back as two beats, LO then HI.

## Interface
- ALU_LAT, 1: cycles from issue to Z capture for single-result ops (≥1)
- MUL_LAT, 4: same, for mul (≥1)
- DIV_LAT, 8: same, for div (≥1)

- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_opcode  in  5  ALU opcode
- req_a  in  32  first operand, goes to ALU Ry
- req_b  in  32  second operand, goes to ALU Rb
- req_rd  in  4  destination GPR index
- alu_ry  out  32  to ALU Ry
- alu_rb  out  32  to ALU Rb
- alu_opcode  out  5  to ALU opcode
- alu_c  in  64  ALU result; div gives {remainder, quotient}
- wb_valid  out  1  writeback beat present
- wb_ready  in  1  register file accepts beat
- wb_data  out  32  beat data
- wb_dest  out  2  00 GPR, 01 LO, 10 HI
- wb_rd  out  4  latched req_rd
- busy  out  1  state ≠ IDLE
- illegal  out  1  one-cycle pulse on an illegal opcode

## Operation
- Legal opcodes:
  - single-result: 00011 add, 00100 sub, 00101 shr, 00110 shra, 00111 shl, 01000 ror, 01001 rol, 01010 and, 01100 or, 10001 neg, 10010 not
  - two-result: 01111 mul, 10000 div
  - all others illegal, including 01011, 01101 and 01110.
- States: IDLE, EXEC, WB0, WB1.
- IDLE:
  - Acceptance happens on req_valid & req_ready.
  - Legal opcode: latch a, b, opcode and rd into alu_ry, alu_rb, alu_opcode and wb_rd.
  - Load counter with LAT−1, where LAT is MUL_LAT for mul, DIV_LAT for div, else ALU_LAT. Go to EXEC.
  - Illegal opcode: pulse illegal for the next cycle and stay in IDLE. No ALU outputs change.
- EXEC:
  - Counter ≠ 0: decrement.
  - Counter = 0: Z ← alu_c, go to WB0.
- WB0:
  - wb_valid=1, wb_data=Z[31:0].
  - wb_dest=01 for mul/div, otherwise 00.
  - On wb_ready: go to WB1 for mul/div, otherwise IDLE.
- WB1:
  - wb_valid=1, wb_data=Z[63:32], wb_dest=10.
  - On wb_ready: go to IDLE.
- Result mapping:
  - mul: LO = product[31:0], HI = product[63:32].
  - div: LO = quotient, HI = remainder.
  - Single-result ops write back Z[31:0] only.
- alu_ry, alu_rb and alu_opcode hold their last issued values outside EXEC; they never change except on acceptance.
- The block does no arithmetic and no width conversion of its own.

## Timing
- Reset (clear low, immediate):
  - State IDLE.
  - Z, alu_ry, alu_rb, alu_opcode, wb_data, wb_rd, wb_dest = 0.
  - wb_valid=0, busy=0, illegal=0.
  - req_ready=1 once in IDLE.
- Reset mid-operation aborts the operation. No partial beat may be presented after clear deasserts.
- Accept at edge T0 → Z capture at edge T0+LAT → wb_valid high from the cycle after T0+LAT.
- With ALU_LAT=1 and wb_ready held high:
  - writeback handshake at T0+2
  - next accept no earlier than T0+3
- Mul/div with wb_ready held high: LO handshake at T0+LAT+1, HI handshake at T0+LAT+2.
- Backpressure: while wb_valid & !wb_ready, wb_data, wb_dest and wb_rd stay stable.
- No overlap: req_ready=0 from the acceptance edge until the final writeback handshake.
- illegal is high for exactly the one cycle after the accepting edge.
- req_valid arriving together with the final wb handshake is not accepted that cycle. It is accepted on the following edge.

## Test plan
- Reset: hold clear low with random inputs → req_ready=1, wb_valid=0, busy=0, illegal=0, all ALU drive outputs 0.
- Add, 5+7, rd=3, ALU_LAT=1, bench connects the team's ALU → single beat wb_data=12, wb_dest=00, wb_rd=3, handshake at T0+2; busy low the next cycle.
- Mul, 0x00010000×0x00010000, MUL_LAT=4, wb_ready low for 3 cycles → LO beat 0x00000000/01 held stable, then HI beat 0x00000001/10; no third beat.
- Div, 17÷5, DIV_LAT=8 → capture at T0+8; LO beat 3, HI beat 2.
- Illegal opcode 01101 → illegal pulses for one cycle, wb_valid stays 0, alu_opcode unchanged, req_ready stays 1.
- clear pulsed low during EXEC of a div → every output drops to its reset value at once with no wb_valid; a following add of 1+1 completes with wb_data=2.

Source files
------------

// File: rtl/alu_issue_wb_if.sv
// Request, ALU drive and writeback signals of the ALU issue/writeback sequencer.
// The sequencer takes the slave view; the register-file/ALU side takes master.
interface alu_issue_wb_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_rd;
    logic [31:0] alu_ry;
    logic [31:0] alu_rb;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [1:0]  wb_dest;
    logic [3:0]  wb_rd;
    logic        busy;
    logic        illegal;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_rd,
        input  alu_c, wb_ready,
        output req_ready, alu_ry, alu_rb, alu_opcode,
        output wb_valid, wb_data, wb_dest, wb_rd, busy, illegal
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_rd,
        output alu_c, wb_ready,
        input  req_ready, alu_ry, alu_rb, alu_opcode,
        input  wb_valid, wb_data, wb_dest, wb_rd, busy, illegal
    );
endinterface

// File: rtl/alu_issue_wb.sv
// Issues one ALU operation at a time, waits its latency, captures the 64-bit
// result into Z and returns it as one beat (or LO/HI beats for mul/div).
module alu_issue_wb #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8
) (
    input logic          clock,
    input logic          clear,
    alu_issue_wb_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB0,
        S_WB1
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [63:0] r_z;
    logic        r_two;
    logic [31:0] r_ry;
    logic [31:0] r_rb;
    logic [4:0]  r_op;
    logic [3:0]  r_rd;
    logic        r_illegal;

    logic        w_accept;
    logic        w_legal;
    logic        w_two;
    logic [15:0] w_lat;

    assign w_accept = bus.req_valid & (r_state == S_IDLE);

    always_comb begin
        w_legal = 1'b0;
        w_two   = 1'b0;
        w_lat   = 16'(ALU_LAT - 1);
        case (bus.req_opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010,
            5'b01100, 5'b10001, 5'b10010: w_legal = 1'b1;
            OP_MUL: begin
                w_legal = 1'b1;
                w_two   = 1'b1;
                w_lat   = 16'(MUL_LAT - 1);
            end
            OP_DIV: begin
                w_legal = 1'b1;
                w_two   = 1'b1;
                w_lat   = 16'(DIV_LAT - 1);
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_z       <= '0;
            r_two     <= 1'b0;
            r_ry      <= '0;
            r_rb      <= '0;
            r_op      <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_ry    <= bus.req_a;
                            r_rb    <= bus.req_b;
                            r_op    <= bus.req_opcode;
                            r_rd    <= bus.req_rd;
                            r_two   <= w_two;
                            r_cnt   <= w_lat;
                            r_state <= S_EXEC;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_z     <= bus.alu_c;
                        r_state <= S_WB0;
                    end
                end
                S_WB0: begin
                    if (bus.wb_ready) begin
                        r_state <= r_two ? S_WB1 : S_IDLE;
                    end
                end
                S_WB1: begin
                    if (bus.wb_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Beat data comes straight from Z, so it cannot move under backpressure.
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.wb_valid   = (r_state == S_WB0) | (r_state == S_WB1);
    assign bus.wb_data    = (r_state == S_WB1) ? r_z[63:32] : r_z[31:0];
    assign bus.wb_dest    = (r_state == S_WB1) ? 2'b10 :
                            ((r_state == S_WB0) & r_two) ? 2'b01 : 2'b00;
    assign bus.wb_rd      = r_rd;
    assign bus.alu_ry     = r_ry;
    assign bus.alu_rb     = r_rb;
    assign bus.alu_opcode = r_op;
    assign bus.illegal    = r_illegal;
endmodule
